sdram_wr_burst: RTL and testbench

SDRAM_WR_BURST -- requirements
Module: sdram_wr_burst

---
 rtl/sdram_wr_burst.sv | 168 ++++++++++++++++
 tb/tb_sdram_wr_burst.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wr_burst.sv
// SDRAM write-burst controller: opens a row, streams show-ahead data as a
// full-page write terminated by BURST_TERM, precharges, and repeats per page
// segment until the requested word count has been written.
module sdram_wr_burst #(
    parameter int DATA_W   = 16,
    parameter int BANK_W   = 2,
    parameter int ROW_W    = 13,
    parameter int COL_W    = 9,
    parameter int LEN_W    = 10,
    parameter int TRCD_CLK = 2,
    parameter int TWR_CLK  = 2,
    parameter int TRP_CLK  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [BANK_W+ROW_W+COL_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [LEN_W-1:0]                wr_burst_len,
    output logic [3:0]                      wr_cmd,
    output logic [BANK_W-1:0]               wr_bank_addr,
    output logic [ROW_W-1:0]                wr_sdram_addr,
    output logic [DATA_W-1:0]               wr_sdram_data,
    output logic                            wr_sdram_en,
    output logic                            wr_ack,
    output logic                            wr_end,
    output logic                            wr_busy
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_BT   = 4'b0110;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    // segment counters must hold both a full page (2^COL_W) and any length
    localparam int SW = (LEN_W > COL_W + 1) ? LEN_W : COL_W + 1;
    localparam int TW = 8;

    typedef enum logic [3:0] {IDLE, ACT, TRCD, WR, BT, TWR, PRE, TRP, END} state_t;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } addr_t;

    state_t            state, nxt;
    addr_t             cur;
    logic [LEN_W-1:0]  rem;
    logic [SW-1:0]     seg_len, beat;
    logic [TW-1:0]     tmr;
    logic [SW-1:0]     page_room, seg_next;

    // words left before the page boundary, and the segment the next ACT opens
    assign page_room = (SW'(1) << COL_W) - SW'(cur.col);
    assign seg_next  = (SW'(rem) < page_room) ? SW'(rem) : page_room;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // next state and Moore-style command/strobe decode
    always_comb begin
        nxt           = state;
        wr_cmd        = CMD_NOP;
        wr_bank_addr  = cur.bank;
        wr_sdram_addr = '0;
        wr_sdram_en   = 1'b0;
        wr_ack        = 1'b0;
        wr_end        = 1'b0;
        wr_busy       = 1'b1;
        case (state)
            IDLE: begin
                wr_busy      = 1'b0;
                wr_bank_addr = '0;
                if (wr_en) nxt = (wr_burst_len == '0) ? END : ACT;
            end
            ACT: begin
                wr_cmd        = CMD_ACT;
                wr_sdram_addr = cur.row;
                nxt           = TRCD;
            end
            TRCD: begin
                // ack one cycle ahead so the first word is registered for WR
                if (tmr == TW'(TRCD_CLK - 1)) begin
                    wr_ack = 1'b1;
                    nxt    = WR;
                end
            end
            WR: begin
                wr_sdram_en = 1'b1;
                if (beat == '0) begin
                    wr_cmd        = CMD_WR;
                    wr_sdram_addr = ROW_W'(cur.col);   // A10 stays 0: no auto-precharge
                end
                if (beat == seg_len - SW'(1)) nxt = BT;
                else                           wr_ack = 1'b1;
            end
            BT: begin
                wr_cmd = CMD_BT;
                nxt    = TWR;
            end
            TWR: begin
                if (tmr == TW'(TWR_CLK - 1)) nxt = PRE;
            end
            PRE: begin
                wr_cmd = CMD_PRE;              // A10 = 0: current bank only
                nxt    = TRP;
            end
            TRP: begin
                if (tmr == TW'(TRP_CLK - 1)) nxt = (rem != '0) ? ACT : END;
            end
            END: begin
                wr_end = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // wait-state timer: restarts on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             tmr <= '0;
        else if (nxt == state && state != IDLE) tmr <= tmr + TW'(1);
        else                                   tmr <= '0;
    end

    // request latch, segment bookkeeping and page advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= '0;
            rem     <= '0;
            seg_len <= '0;
            beat    <= '0;
        end else begin
            case (state)
                IDLE: if (wr_en) begin
                    cur <= wr_addr;
                    rem <= wr_burst_len;
                end
                ACT: begin
                    seg_len <= seg_next;
                    beat    <= '0;
                end
                WR: begin
                    beat <= beat + SW'(1);
                    if (nxt == BT) rem <= rem - LEN_W'(seg_len);
                end
                TRP: if (nxt == ACT) begin
                    // row wrap carries into bank, which wraps modulo 2^BANK_W
                    cur.col              <= '0;
                    {cur.bank, cur.row}  <= {cur.bank, cur.row} + (BANK_W + ROW_W)'(1);
                end
                default: ;
            endcase
        end
    end

    // data register: captures show-ahead data on ack, holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       wr_sdram_data <= '0;
        else if (wr_ack) wr_sdram_data <= wr_data;
    end

endmodule

// File: tb/tb_sdram_wr_burst.sv
// Directed bench for sdram_wr_burst: vector table of transfers checked against
// a linear-address / data-order model, plus reset-abort and held-request cases.
module tb_sdram_wr_burst;

    localparam logic [3:0] NOP = 4'b0111, ACTV = 4'b0011, WRC = 4'b0100,
                           BTC = 4'b0110, PREC = 4'b0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [23:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [9:0]  wr_burst_len = '0;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_bank_addr;
    logic [12:0] wr_sdram_addr;
    logic [15:0] wr_sdram_data;
    logic        wr_sdram_en, wr_ack, wr_end, wr_busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sdram_wr_burst dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_burst_len(wr_burst_len), .wr_cmd(wr_cmd),
        .wr_bank_addr(wr_bank_addr), .wr_sdram_addr(wr_sdram_addr),
        .wr_sdram_data(wr_sdram_data), .wr_sdram_en(wr_sdram_en),
        .wr_ack(wr_ack), .wr_end(wr_end), .wr_busy(wr_busy)
    );

    typedef struct {
        logic [23:0] addr;
        logic [9:0]  len;
        int          lat;    // sampled cycle of wr_end, request edge = cycle 0
        int          acts;
        logic [1:0]  lb;     // bank/row of last ACTIVE (0/0 if none)
        logic [12:0] lr;
    } vec_t;

    typedef struct {
        int lat, acts, acks, beats, bts, ends, busy_bad, idle_bad;
        logic [1:0]  lb;
        logic [12:0] lr;
    } res_t;

    function automatic logic [23:0] mk(input int b, input int r, input int c);
        logic [23:0] a;
        a = {2'(b), 13'(r), 9'(c)};
        return a;
    endfunction

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 40503 + 4660);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and monitor the transfer; every data beat is checked
    // against address addr+i and data pat(i).
    task automatic run_xfer(input logic [23:0] addr, input logic [9:0] len, output res_t r);
        int          idx, sb;
        logic        ack_prev;
        logic [1:0]  act_b;
        logic [12:0] act_r;
        logic [8:0]  wcol;
        logic [23:0] got_a, exp_a;
        r = '{default: 0};
        idx = 0; sb = 0; ack_prev = 1'b0;
        act_b = '0; act_r = '0; wcol = '0;
        @(negedge clk);
        wr_addr = addr; wr_burst_len = len; wr_en = 1'b1; wr_data = pat(0);
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (ack_prev) begin idx++; wr_data = pat(idx); end
            ack_prev = wr_ack;
            if (wr_busy !== 1'b1) r.busy_bad++;
            if (wr_cmd == ACTV) begin
                r.acts++; act_b = wr_bank_addr; act_r = wr_sdram_addr;
            end
            if (wr_cmd == WRC) begin
                wcol = wr_sdram_addr[8:0]; sb = 0;
                chk("write A10", 64'(wr_sdram_addr[10]), 64'd0);
            end
            if (wr_sdram_en) begin
                got_a = {act_b, act_r, 9'(wcol + 9'(sb))};
                exp_a = addr + 24'(r.beats);
                chk("beat addr", 64'(got_a), 64'(exp_a));
                chk("beat data", 64'(wr_sdram_data), 64'(pat(r.beats)));
                r.beats++; sb++;
            end
            if (wr_cmd == BTC) begin
                r.bts++;
                chk("bt en", 64'(wr_sdram_en), 64'd0);
            end
            if (wr_cmd == PREC) begin
                chk("pre bank", 64'(wr_bank_addr), 64'(act_b));
                chk("pre A10", 64'(wr_sdram_addr[10]), 64'd0);
            end
            if (wr_ack) r.acks++;
            if (wr_end) begin
                r.ends++; r.lat = cyc;
                break;
            end
        end
        if (r.ends == 0) chk("xfer timeout", 64'd1, 64'd0);
        r.lb = act_b; r.lr = act_r;
        @(negedge clk);
        if (wr_busy !== 1'b0 || wr_end !== 1'b0 || wr_cmd !== NOP) r.idle_bad = 1;
    endtask

    vec_t vt[7];

    initial begin
        res_t r;
        int   beats, acts, ends, bad;

        vt[0] = '{mk(0, 0, 0),      10'd2,    12,   1, 2'd0, 13'd0};
        vt[1] = '{mk(0, 3, 0),      10'd512,  522,  1, 2'd0, 13'd3};
        vt[2] = '{mk(0, 5, 510),    10'd4,    23,   2, 2'd0, 13'd6};
        vt[3] = '{mk(1, 8191, 511), 10'd2,    21,   2, 2'd2, 13'd0};
        vt[4] = '{mk(3, 100, 7),    10'd0,    1,    0, 2'd0, 13'd0};
        vt[5] = '{mk(3, 8191, 500), 10'd20,   39,   2, 2'd0, 13'd0};
        vt[6] = '{mk(2, 10, 0),     10'd1023, 1042, 2, 2'd2, 13'd11};

        // reset state
        #1;
        chk("rst cmd",  64'(wr_cmd), 64'(NOP));
        chk("rst bank", 64'(wr_bank_addr), 64'd0);
        chk("rst addr", 64'(wr_sdram_addr), 64'd0);
        chk("rst data", 64'(wr_sdram_data), 64'd0);
        chk("rst strobes", 64'({wr_sdram_en, wr_ack, wr_end, wr_busy}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_xfer(vt[i].addr, vt[i].len, r);
            chk($sformatf("v%0d latency", i), 64'(r.lat), 64'(vt[i].lat));
            chk($sformatf("v%0d acts", i),    64'(r.acts), 64'(vt[i].acts));
            chk($sformatf("v%0d acks", i),    64'(r.acks), 64'(vt[i].len));
            chk($sformatf("v%0d beats", i),   64'(r.beats), 64'(vt[i].len));
            chk($sformatf("v%0d bts", i),     64'(r.bts), 64'(vt[i].acts));
            chk($sformatf("v%0d last bank", i), 64'(r.lb), 64'(vt[i].lb));
            chk($sformatf("v%0d last row", i),  64'(r.lr), 64'(vt[i].lr));
            chk($sformatf("v%0d busy", i),    64'(r.busy_bad), 64'd0);
            chk($sformatf("v%0d idle", i),    64'(r.idle_bad), 64'd0);
        end

        // reset pulse during the third beat of a length-8 transfer
        @(negedge clk);
        wr_addr = mk(0, 7, 0); wr_burst_len = 10'd8; wr_en = 1'b1; wr_data = 16'hBEEF;
        beats = 0;
        for (int cyc = 0; cyc < 50 && beats < 3; cyc++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (wr_sdram_en) beats++;
        end
        chk("abort reached beat3", 64'(beats), 64'd3);
        reset = 1'b1;
        #1;
        chk("abort cmd",  64'(wr_cmd), 64'(NOP));
        chk("abort bank", 64'(wr_bank_addr), 64'd0);
        chk("abort addr", 64'(wr_sdram_addr), 64'd0);
        chk("abort data", 64'(wr_sdram_data), 64'd0);
        chk("abort strobes", 64'({wr_sdram_en, wr_ack, wr_end, wr_busy}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (wr_end !== 1'b0 || wr_busy !== 1'b0 || wr_cmd !== NOP) bad++;
        end
        chk("abort quiet", 64'(bad), 64'd0);
        run_xfer(mk(1, 2, 3), 10'd2, r);
        chk("post-abort latency", 64'(r.lat), 64'd12);
        chk("post-abort acks",    64'(r.acks), 64'd2);
        chk("post-abort beats",   64'(r.beats), 64'd2);
        chk("post-abort bank",    64'(r.lb), 64'd1);

        // len 0 with wr_en held: END, IDLE, END again
        @(negedge clk);
        wr_addr = mk(0, 0, 0); wr_burst_len = 10'd0; wr_en = 1'b1;
        @(negedge clk);
        chk("len0 end c1",  64'({wr_end, wr_busy, wr_cmd}), 64'({1'b1, 1'b1, NOP}));
        @(negedge clk);
        chk("len0 idle c2", 64'({wr_end, wr_busy, wr_cmd}), 64'({1'b0, 1'b0, NOP}));
        @(negedge clk);
        chk("len0 end c3",  64'(wr_end), 64'd1);
        wr_en = 1'b0;
        @(negedge clk);

        // len 2 with wr_en held through the whole transfer: no restart while busy
        @(negedge clk);
        wr_addr = mk(0, 0, 0); wr_burst_len = 10'd2; wr_en = 1'b1;
        acts = 0; ends = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (wr_cmd == ACTV) acts++;
            if (wr_end) ends++;
        end
        chk("hold acts",  64'(acts), 64'd1);
        chk("hold end@12", 64'({ends, 1'b0} | wr_end), 64'({32'd1, 1'b0} | 1'b1));
        @(negedge clk);
        chk("hold idle",  64'(wr_busy), 64'd0);
        @(negedge clk);
        chk("hold restart", 64'(wr_cmd), 64'(ACTV));
        wr_en = 1'b0;
        ends = 0;
        for (int cyc = 0; cyc < 30 && ends == 0; cyc++) begin
            @(negedge clk);
            if (wr_end) ends++;
        end
        chk("hold restart end", 64'(ends), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
